mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-port byte memory (8-bit data, 13-bit address) between requester 0 (instruction fetch) and requester 1 (data load/store).
- Accepts a 1- or 2-byte transfer per grant and steps the memory address one byte per cycle.
- Assembles 16-bit read data little-endian and returns a one-cycle done pulse to the owning requester.
- Sits between the multi-cycle CPU control/datapath and the memory's address, write-enable and data ports.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing a single-port byte memory.
// Each grant moves 1 or 2 bytes, little-endian, and ends with a one-cycle done pulse.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 13,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [15:0]       wdata0,
    output logic [15:0]       rdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic              size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata1,
    output logic [15:0]       rdata1,
    output logic              done1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              r_owner, r_we, r_size, r_cnt, r_lg;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_wdata, r_rdata;
    logic              w_grant, w_sel, w_busy, w_done;

    // Port select on a tie: fixed priority, or the port that did not win last time.
    always_comb begin
        w_grant = req0 | req1;
        if (req0 && req1) begin
            w_sel = FIXED_PRI ? 1'b0 : ~r_lg;
        end else begin
            w_sel = req1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_grant) w_state_d = StBusy;
            StBusy:  if (r_cnt == r_size) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_base  <= '0;
            r_we    <= 1'b0;
            r_size  <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= 1'b0;
            r_rdata <= '0;
            r_lg    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && w_grant) begin
                r_owner <= w_sel;
                r_base  <= w_sel ? addr1 : addr0;
                r_we    <= w_sel ? we1 : we0;
                r_size  <= w_sel ? size1 : size0;
                r_wdata <= w_sel ? wdata1 : wdata0;
                r_cnt   <= 1'b0;
                r_rdata <= '0;
                r_lg    <= w_sel;
            end
            if (r_state == StBusy) begin
                if (!r_we) begin
                    if (r_cnt) r_rdata[15:8] <= mem_rdata;
                    else       r_rdata[7:0]  <= mem_rdata;
                end
                if (r_cnt != r_size) r_cnt <= 1'b1;
            end
        end
    end

    // Memory strobes come from the state register only, so reset kills mem_we at once.
    always_comb begin
        w_busy    = (r_state == StBusy);
        w_done    = (r_state == StDone);
        mem_we    = w_busy & r_we;
        mem_addr  = w_busy ? (r_base + {{(ADDR_W-1){1'b0}}, r_cnt}) : '0;
        mem_wdata = w_busy ? (r_cnt ? r_wdata[15:8] : r_wdata[7:0]) : '0;
        gnt0      = (w_busy | w_done) & ~r_owner;
        gnt1      = (w_busy | w_done) & r_owner;
        done0     = w_done & ~r_owner;
        done1     = w_done & r_owner;
        rdata0    = done0 ? r_rdata : '0;
        rdata1    = done1 ? r_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-array memory model plus a done/rdata scoreboard.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        a_req0, a_we0, a_size0, a_req1, a_we1, a_size1;
    logic [12:0] a_addr0, a_addr1, a_mem_addr;
    logic [15:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1;
    logic        a_done0, a_done1, a_gnt0, a_gnt1, a_mem_we;
    logic [7:0]  a_mem_wdata, a_mem_rdata;
    logic        b_req0, b_req1;
    logic [12:0] b_mem_addr;
    logic [15:0] b_rdata0, b_rdata1;
    logic        b_done0, b_done1, b_gnt0, b_gnt1, b_mem_we;
    logic [7:0]  b_mem_wdata, b_mem_rdata;

    logic [7:0]  mem_a [0:8191];

    typedef struct packed {
        logic        port;
        logic [15:0] rd;
    } sb_t;
    sb_t sb_a[$];

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(13), .FIXED_PRI(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .we0(a_we0), .size0(a_size0), .addr0(a_addr0), .wdata0(a_wdata0),
        .rdata0(a_rdata0), .done0(a_done0),
        .req1(a_req1), .we1(a_we1), .size1(a_size1), .addr1(a_addr1), .wdata1(a_wdata1),
        .rdata1(a_rdata1), .done1(a_done1),
        .gnt0(a_gnt0), .gnt1(a_gnt1),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.ADDR_W(13), .FIXED_PRI(1'b1)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(1'b0), .size0(1'b0), .addr0(13'h0010), .wdata0(16'h0000),
        .rdata0(b_rdata0), .done0(b_done0),
        .req1(b_req1), .we1(1'b0), .size1(1'b0), .addr1(13'h0020), .wdata1(16'h0000),
        .rdata1(b_rdata1), .done1(b_done1),
        .gnt0(b_gnt0), .gnt1(b_gnt1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata)
    );

    assign a_mem_rdata = mem_a[a_mem_addr];
    // Pattern memory for the second instance: low address byte folded with the high bits.
    assign b_mem_rdata = b_mem_addr[7:0] ^ {3'b000, b_mem_addr[12:8]};

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard side: every done pulse must match the oldest queued transfer.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot_a", {31'd0, a_gnt0 & a_gnt1}, 32'd0);
            chk("gnt_onehot_b", {31'd0, b_gnt0 & b_gnt1}, 32'd0);
            if (!a_done0) chk("rdata0_quiet", a_rdata0, 32'd0);
            if (!a_done1) chk("rdata1_quiet", a_rdata1, 32'd0);
            if (a_done0 || a_done1) begin
                chk("done_expected", {31'd0, sb_a.size() != 0}, 32'd1);
                if (sb_a.size() != 0) begin
                    sb_t e;
                    e = sb_a.pop_front();
                    chk("done_port", {31'd0, a_done1}, {31'd0, e.port});
                    chk("done_rdata", e.port ? a_rdata1 : a_rdata0, {16'd0, e.rd});
                end
            end
        end
    end

    task automatic drive_a(input bit port, input bit on, input bit we, input bit size,
                           input logic [12:0] addr, input logic [15:0] wdata);
        if (port) begin
            a_req1 = on; a_we1 = we; a_size1 = size; a_addr1 = addr; a_wdata1 = wdata;
        end else begin
            a_req0 = on; a_we0 = we; a_size0 = size; a_addr0 = addr; a_wdata0 = wdata;
        end
    endtask

    // One full transfer on instance A, checking every BUSY byte and the done cycle.
    task automatic xfer_a(input bit port, input bit we, input bit size, input logic [12:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd);
        logic [12:0] ea;
        drive_a(port, 1'b1, we, size, addr, wdata);
        sb_a.push_back('{port, exp_rd});
        for (int c = 0; c <= int'(size); c++) begin
            tick();
            ea = addr + 13'(c);
            chk("gnt_own", {31'd0, port ? a_gnt1 : a_gnt0}, 32'd1);
            chk("gnt_other", {31'd0, port ? a_gnt0 : a_gnt1}, 32'd0);
            chk("mem_we_busy", {31'd0, a_mem_we}, {31'd0, we});
            chk("mem_addr", {19'd0, a_mem_addr}, {19'd0, ea});
            if (we) chk("mem_wdata", {24'd0, a_mem_wdata}, {24'd0, c ? wdata[15:8] : wdata[7:0]});
            chk("done_early", {30'd0, a_done1, a_done0}, 32'd0);
        end
        tick();
        chk("done_cycle", {30'd0, a_done1, a_done0}, port ? 32'd2 : 32'd1);
        chk("mem_we_done", {31'd0, a_mem_we}, 32'd0);
        drive_a(port, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0);
        tick();
        chk("idle_gnt", {30'd0, a_gnt1, a_gnt0}, 32'd0);
        chk("idle_addr", {19'd0, a_mem_addr}, 32'd0);
    endtask

    initial begin
        // 1 = port 0 owns, 2 = port 1 owns, 0 = idle
        int own_a [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
        int own_b [9]  = '{1, 1, 0, 1, 1, 0, 2, 2, 0};
        rst = 1'b1;
        b_req0 = 1'b0; b_req1 = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0);
        repeat (2) tick();
        chk("rst_gnt", {30'd0, a_gnt1, a_gnt0}, 32'd0);
        chk("rst_done", {30'd0, a_done1, a_done0}, 32'd0);
        chk("rst_mem_we", {31'd0, a_mem_we}, 32'd0);
        chk("rst_mem_addr", {19'd0, a_mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, a_mem_wdata}, 32'd0);
        chk("rst_rdata", {a_rdata1, a_rdata0}, 32'd0);
        rst = 1'b0;
        tick();

        xfer_a(1'b0, 1'b1, 1'b1, 13'h0100, 16'hBEEF, 16'h0000);
        chk("mem_0100", {24'd0, mem_a[13'h0100]}, 32'hEF);
        chk("mem_0101", {24'd0, mem_a[13'h0101]}, 32'hBE);
        xfer_a(1'b0, 1'b0, 1'b1, 13'h0100, 16'h0000, 16'hBEEF);
        xfer_a(1'b0, 1'b0, 1'b0, 13'h0101, 16'h0000, 16'h00BE);
        xfer_a(1'b0, 1'b1, 1'b1, 13'h1FFF, 16'h1234, 16'h0000);
        chk("mem_1fff", {24'd0, mem_a[13'h1FFF]}, 32'h34);
        chk("mem_0000", {24'd0, mem_a[13'h0000]}, 32'h12);
        xfer_a(1'b0, 1'b0, 1'b1, 13'h1FFF, 16'h0000, 16'h1234);
        xfer_a(1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h0000, 16'h0034);

        // Round-robin contention: both held, 1-byte reads.
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h0100, 16'd0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 13'h0101, 16'd0);
        sb_a.push_back('{1'b0, 16'h00EF});
        sb_a.push_back('{1'b1, 16'h00BE});
        sb_a.push_back('{1'b0, 16'h00EF});
        sb_a.push_back('{1'b1, 16'h00BE});
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_gnt", {30'd0, a_gnt1, a_gnt0}, 32'(own_a[k]));
            chk("rr_done", {30'd0, a_done1, a_done0}, (k % 3 == 1) ? 32'(own_a[k]) : 32'd0);
            if (k == 10) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
        end
        tick();
        chk("rr_quiet", {30'd0, a_gnt1, a_gnt0}, 32'd0);

        // Reset in the middle of a 2-byte write at 0x0100.
        drive_a(1'b0, 1'b1, 1'b1, 1'b1, 13'h0100, 16'hA55A);
        tick();
        chk("rb_we", {31'd0, a_mem_we}, 32'd1);
        tick();
        chk("rb_byte0", {24'd0, mem_a[13'h0100]}, 32'h5A);
        rst = 1'b1;
        a_req0 = 1'b0;
        #1;
        chk("rb_we_async", {31'd0, a_mem_we}, 32'd0);
        chk("rb_gnt_async", {30'd0, a_gnt1, a_gnt0}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rb_no_done", {30'd0, a_done1, a_done0}, 32'd0);
        chk("rb_byte1_kept", {24'd0, mem_a[13'h0101]}, 32'hBE);
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h0100, 16'd0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 13'h0101, 16'd0);
        sb_a.push_back('{1'b0, 16'h005A});
        tick();
        chk("rb_tie_gnt", {30'd0, a_gnt1, a_gnt0}, 32'd1);
        tick();
        chk("rb_tie_done", {30'd0, a_done1, a_done0}, 32'd1);
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        tick();
        chk("rb_tie_idle", {30'd0, a_gnt1, a_gnt0}, 32'd0);

        // Fixed priority instance: port 0 always wins until it lets go.
        b_req0 = 1'b1;
        b_req1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("fp_gnt", {30'd0, b_gnt1, b_gnt0}, 32'(own_b[k]));
            chk("fp_we", {24'd0, b_mem_wdata} | {31'd0, b_mem_we}, 32'd0);
            chk("fp_done", {30'd0, b_done1, b_done0}, (k % 3 == 1) ? 32'(own_b[k]) : 32'd0);
            if (k % 3 == 1) chk("fp_rdata", {b_rdata1, b_rdata0},
                                (own_b[k] == 2) ? 32'h0020_0000 : 32'h0000_0010);
            if (k == 4) b_req0 = 1'b0;
            if (k == 7) b_req1 = 1'b0;
        end

        chk("sb_drained", sb_a.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
